// File: rtl/div_float.sv
// Sequential IEEE-754 single-precision divider (out = op1 / op2).
// Radix-2 restoring mantissa division, one quotient bit per cycle, truncating.
module div_float #(
  parameter int FLOAT_WIDTH = 32,
  parameter int EXP_WIDTH   = 8,
  parameter int MANT_WIDTH  = 23,
  parameter int BIAS        = 127
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [FLOAT_WIDTH-1:0] op1,
  input  logic [FLOAT_WIDTH-1:0] op2,
  output logic [FLOAT_WIDTH-1:0] out_reg,
  output logic                   nan_reg,
  output logic                   overflow_reg,
  output logic                   underflow_reg,
  output logic                   zero_reg,
  output logic                   div_by_zero_reg,
  output logic                   done_reg,
  output logic                   busy
);

  localparam int EW = EXP_WIDTH;
  localparam int MW = MANT_WIDTH;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] PREP   = 2'd1;
  localparam logic [1:0] DIVIDE = 2'd2;
  localparam logic [1:0] NORM   = 2'd3;

  localparam logic signed [9:0] EXP_MAX = 10'((1 << EW) - 1);
  localparam logic [FLOAT_WIDTH-1:0] QNAN = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

  logic [1:0]             state_q, state_d;
  logic [FLOAT_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [MW+2:0]          rem_q, rem_d;
  logic [MW:0]            dvs_q, dvs_d;
  logic [MW+1:0]          quo_q, quo_d;
  logic signed [9:0]      exp_q, exp_d;
  logic [4:0]             cnt_q, cnt_d;
  logic                   sign_q, sign_d;
  logic [FLOAT_WIDTH-1:0] out_q, out_d;
  logic                   nan_q, nan_d, ovf_q, ovf_d, unf_q, unf_d;
  logic                   zero_q, zero_d, dbz_q, dbz_d, done_q, done_d;

  logic [EW-1:0]     e1, e2;
  logic [MW-1:0]     m1, m2;
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, s;
  logic [MW+2:0]     dvs_ext, rem_sub;
  logic signed [9:0] exp_n;
  logic [MW-1:0]     frac_n;

  assign e1 = a_q[FLOAT_WIDTH-2 -: EW];
  assign e2 = b_q[FLOAT_WIDTH-2 -: EW];
  assign m1 = a_q[MW-1:0];
  assign m2 = b_q[MW-1:0];
  assign s  = a_q[FLOAT_WIDTH-1] ^ b_q[FLOAT_WIDTH-1];

  // Exponent zero covers both true zero and flushed denormals.
  assign a_zero = (e1 == '0);
  assign b_zero = (e2 == '0);
  assign a_inf  = (e1 == '1) && (m1 == '0);
  assign b_inf  = (e2 == '1) && (m2 == '0);
  assign a_nan  = (e1 == '1) && (m1 != '0);
  assign b_nan  = (e2 == '1) && (m2 != '0);

  assign dvs_ext = {2'b00, dvs_q};
  assign rem_sub = rem_q - dvs_ext;

  assign exp_n  = quo_q[MW+1] ? exp_q : exp_q - 10'sd1;
  assign frac_n = quo_q[MW+1] ? quo_q[MW:1] : quo_q[MW-1:0];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    exp_d   = exp_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    out_d   = out_q;
    nan_d   = nan_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    zero_d  = zero_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = op1;
          b_d     = op2;
          state_d = PREP;
        end
      end
      PREP: begin
        sign_d = s;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf) ||
            a_inf || b_zero || a_zero || b_inf) begin
          nan_d   = 1'b0;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          zero_d  = 1'b0;
          dbz_d   = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
          if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            out_d = QNAN;
            nan_d = 1'b1;
          end else if (a_inf) begin
            out_d = {s, {EW{1'b1}}, {MW{1'b0}}};
          end else if (b_zero) begin
            out_d = {s, {EW{1'b1}}, {MW{1'b0}}};
            dbz_d = 1'b1;
          end else begin
            out_d  = {s, {(FLOAT_WIDTH-1){1'b0}}};
            zero_d = 1'b1;
          end
        end else begin
          rem_d   = {2'b01, m1};
          dvs_d   = {1'b1, m2};
          quo_d   = '0;
          exp_d   = $signed({2'b00, e1}) - $signed({2'b00, e2}) + $signed(10'(BIAS));
          cnt_d   = 5'(MW + 2);
          state_d = DIVIDE;
        end
      end
      DIVIDE: begin
        if (rem_q >= dvs_ext) begin
          quo_d = {quo_q[MW:0], 1'b1};
          rem_d = rem_sub << 1;
        end else begin
          quo_d = {quo_q[MW:0], 1'b0};
          rem_d = rem_q << 1;
        end
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) state_d = NORM;
      end
      default: begin
        nan_d   = 1'b0;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        zero_d  = 1'b0;
        dbz_d   = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
        if (exp_n >= EXP_MAX) begin
          out_d = {sign_q, {EW{1'b1}}, {MW{1'b0}}};
          ovf_d = 1'b1;
        end else if (exp_n <= 10'sd0) begin
          out_d  = {sign_q, {(FLOAT_WIDTH-1){1'b0}}};
          unf_d  = 1'b1;
          zero_d = 1'b1;
        end else begin
          out_d = {sign_q, exp_n[EW-1:0], frac_n};
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      exp_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      out_q   <= '0;
      nan_q   <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      zero_q  <= 1'b0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      exp_q   <= exp_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      out_q   <= out_d;
      nan_q   <= nan_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      zero_q  <= zero_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
    end
  end

  assign out_reg         = out_q;
  assign nan_reg         = nan_q;
  assign overflow_reg    = ovf_q;
  assign underflow_reg   = unf_q;
  assign zero_reg        = zero_q;
  assign div_by_zero_reg = dbz_q;
  assign done_reg        = done_q;
  assign busy            = (state_q != IDLE);

endmodule
